load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be exactly the following (name, default, meaning):
- DATA_WIDTH, 32, memory/bus data width; legal values 32 or 64.
- ADDR_WIDTH, 32, byte address width.
REQ-002 Ports SHALL be exactly the following (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst_n, in, 1, synchronous active-low reset.
- in_valid, in, 1, request from execute stage.
- in_ready, out, 1, unit accepts a request.
- in_lsu_op, in, 4, operation code.
- in_addr, in, ADDR_WIDTH, effective byte address, or the passthrough result.
- in_wdata, in, DATA_WIDTH, store data (LSB-aligned).
- out_valid, out, 1, result available.
- out_ready, in, 1, downstream accepts the result.
- out_rdata, out, DATA_WIDTH, load result or passthrough value.
- out_ale, out, 1, address-misaligned flag for this result.
- mem_req, out, 1, memory request.
- mem_gnt, in, 1, memory accepted the request.
- mem_we, out, 1, 1 = write.
- mem_addr, out, ADDR_WIDTH, DATA_WIDTH/8-aligned address.
- mem_wdata, out, DATA_WIDTH, lane-shifted write data.
- mem_wmask, out, DATA_WIDTH/8, byte enables.
- mem_rvalid, in, 1, read data or write acknowledge.
- mem_rdata, in, DATA_WIDTH, read data.
REQ-003 Clocking SHALL be one clock, clk; reset SHALL be rst_n, synchronous and active-low.

Function
REQ-004 Opcodes SHALL be as follows; any other code is passthrough.
- Loads: 0000 LD.B, 0001 LD.H, 0010 LD.W, 1000 LD.BU, 1001 LD.HU; 0011 LD.D only when DATA_WIDTH=64.
- Stores: 0100 ST.B, 0101 ST.H, 0110 ST.W; 0111 ST.D only when DATA_WIDTH=64.
REQ-005 The FSM SHALL have exactly these states and transitions:
- IDLE -> REQ on accept of a memory op.
- IDLE -> DONE on accept of a misaligned or passthrough op.
- REQ -> WAIT when mem_gnt=1.
- WAIT -> DONE when mem_rvalid=1.
- DONE -> IDLE when out_ready=1.
REQ-006 in_ready SHALL be 1 only in IDLE; a request is accepted on the cycle where in_valid and in_ready are both 1.
REQ-007 On accept, op, offset (in_addr low log2(DATA_WIDTH/8) bits), in_addr and in_wdata SHALL be registered; inputs are ignored thereafter.
REQ-008 Memory-side behaviour SHALL be:
- mem_req SHALL be 1 throughout REQ and held until mem_gnt.
- mem_addr, mem_we, mem_wdata and mem_wmask SHALL stay stable while mem_req=1.
- mem_req SHALL be 0 in all other states.
REQ-009 mem_addr SHALL be the registered address with its low log2(DATA_WIDTH/8) bits cleared.
REQ-010 For stores, mem_wmask SHALL be the size mask (B=1, H=11, W=1111, D=all-ones) shifted left by offset, and mem_wdata SHALL be in_wdata shifted left by offset*8.
REQ-011 For loads, mem_wmask SHALL be 0 and mem_we SHALL be 0.
REQ-012 Alignment rules:
- An access is misaligned when offset is not a multiple of its size (H: bit0; W: bits[1:0]; D: bits[2:0]).
- A misaligned access SHALL issue no mem_req and SHALL produce out_ale=1 and out_rdata=0.
REQ-013 Load result: mem_rdata SHALL be captured on mem_rvalid in WAIT, shifted right by offset*8, then sign-extended (B, H, W on 64-bit) or zero-extended (BU, HU) from the access size.
REQ-014 Store result: completion SHALL wait for mem_rvalid as a write acknowledge, and out_rdata SHALL be 0.
REQ-015 Passthrough: out_rdata SHALL be in_addr zero-extended or truncated to DATA_WIDTH; out_ale=0.
REQ-016 out_valid SHALL be 1 only in DONE; out_rdata and out_ale SHALL be held stable until out_ready=1.
REQ-017 Latency: with mem_gnt in the first REQ cycle and mem_rvalid in the first WAIT cycle, out_valid SHALL rise 3 cycles after accept. Passthrough and misaligned ops SHALL take 1 cycle.
REQ-018 mem_rvalid asserted outside WAIT SHALL be ignored.

Reset
REQ-019 While rst_n=0 at a clk edge, the unit SHALL take these values:
- state = IDLE
- mem_req, mem_we, mem_wmask, mem_wdata, mem_addr = 0
- out_valid, out_ale, out_rdata = 0
- in_ready = 1 from the first cycle after reset.
REQ-020 Reset in REQ or WAIT SHALL abandon the access; a later mem_rvalid for it SHALL be ignored under REQ-018.

Structure
REQ-021 The opcode enum, FSM state enum and size-mask function SHALL live in a shared package, lsu_pkg.
REQ-022 Lane alignment and extension SHALL be one combinational sub-module, lsu_align, shared by the load and store paths.

Verification
REQ-023 ST.B, addr 0x1003, wdata 0xAB, DATA_WIDTH=32 -> mem_addr 0x1000, mem_wmask 1000, mem_wdata 0xAB000000, mem_we=1.
REQ-024 LD.H, addr 0x2002, mem_rdata 0x8001_1234 -> out_rdata 0xFFFF8001; LD.HU -> 0x00008001.
REQ-025 LD.W, addr 0x3001 -> no mem_req ever; out_valid 1 cycle after accept; out_ale=1; out_rdata=0.
REQ-026 mem_gnt delayed 4 cycles and out_ready held 0 for 3 cycles -> mem_req and all mem_* outputs stable; out_rdata stable; in_ready=0 throughout.
REQ-027 rst_n=0 during WAIT, then stray mem_rvalid=1 -> state IDLE, out_valid stays 0.
REQ-028 DATA_WIDTH=64, LD.W, addr 0x4004, mem_rdata 0x8000_0000_0000_0000 -> out_rdata 0xFFFFFFFF80000000.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: opcodes, FSM states,
// access-size decode.
package lsu_pkg;

    typedef enum logic [3:0] {
        OP_LD_B  = 4'b0000,
        OP_LD_H  = 4'b0001,
        OP_LD_W  = 4'b0010,
        OP_LD_D  = 4'b0011,
        OP_ST_B  = 4'b0100,
        OP_ST_H  = 4'b0101,
        OP_ST_W  = 4'b0110,
        OP_ST_D  = 4'b0111,
        OP_LD_BU = 4'b1000,
        OP_LD_HU = 4'b1001
    } lsu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        K_PASS,
        K_LOAD,
        K_STORE
    } lsu_kind_e;

    // Byte-enable pattern for an access of 2**size_log2 bytes at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size_log2);
        case (size_log2)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Offset bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_bits(input logic [1:0] size_log2);
        case (size_log2)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Doubleword ops only exist on a 64-bit bus; otherwise they fall to passthrough.
    function automatic lsu_kind_e op_kind(input logic [3:0] op, input bit wide);
        case (op)
            OP_LD_B, OP_LD_H, OP_LD_W, OP_LD_BU, OP_LD_HU: return K_LOAD;
            OP_ST_B, OP_ST_H, OP_ST_W:                     return K_STORE;
            OP_LD_D: return wide ? K_LOAD : K_PASS;
            OP_ST_D: return wide ? K_STORE : K_PASS;
            default: return K_PASS;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: shifts store data up into its lanes and shifts load
// data down, then sign/zero-extends it from the access size.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OFF_W      = $clog2(DATA_WIDTH/8)
) (
    input  logic [OFF_W-1:0]      offset,
    input  logic [1:0]            size_log2,
    input  logic                  sign_ext,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic [DATA_WIDTH-1:0] st_lane,
    output logic [DATA_WIDTH-1:0] ld_value
);

    logic [OFF_W+2:0]      sh_amt;
    logic [DATA_WIDTH-1:0] ld_shift;
    logic [DATA_WIDTH-1:0] ld_keep;
    logic [DATA_WIDTH-1:0] ld_top;
    logic [6:0]            nbits;

    assign sh_amt   = {offset, 3'b000};
    assign st_lane  = st_data << sh_amt;
    assign ld_shift = ld_data >> sh_amt;
    assign nbits    = 7'd8 << size_log2;

    // Keep mask covers the access bits; top marks its sign bit.
    always_comb begin
        ld_keep = '0;
        ld_top  = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            ld_keep[i] = (i < int'(nbits));
            ld_top[i]  = (i == int'(nbits) - 1);
        end
        ld_value = ld_shift & ld_keep;
        if (sign_ext && |(ld_shift & ld_top))
            ld_value = ld_value | ~ld_keep;
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one op, runs one memory
// request/response handshake, then holds the result until taken.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_lsu_op,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]   in_wdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_rdata,
    output logic                    out_ale,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam bit WIDE  = (DATA_WIDTH == 64);

    lsu_state_e       state;
    logic [3:0]       op_q;
    logic [OFF_W-1:0] off_q;

    logic [OFF_W-1:0]      in_off;
    lsu_kind_e             in_kind;
    logic                  in_misaligned;
    logic [NB-1:0]         in_mask;
    logic [OFF_W-1:0]      al_off;
    logic [1:0]            al_size;
    logic                  al_sign;
    logic [DATA_WIDTH-1:0] st_lane;
    logic [DATA_WIDTH-1:0] ld_value;

    assign in_ready      = (state == S_IDLE);
    assign in_off        = in_addr[OFF_W-1:0];
    assign in_kind       = op_kind(in_lsu_op, WIDE);
    assign in_misaligned = (in_kind != K_PASS) &&
                           (|(3'(in_off) & align_bits(in_lsu_op[1:0])));
    assign in_mask       = NB'(size_mask(in_lsu_op[1:0])) << in_off;

    // One aligner serves both paths: the incoming store in IDLE, the
    // captured load response afterwards.
    assign al_off  = (state == S_IDLE) ? in_off : off_q;
    assign al_size = (state == S_IDLE) ? in_lsu_op[1:0] : op_q[1:0];
    assign al_sign = (op_q != OP_LD_BU) && (op_q != OP_LD_HU);

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFF_W      (OFF_W)
    ) u_align (
        .offset    (al_off),
        .size_log2 (al_size),
        .sign_ext  (al_sign),
        .st_data   (in_wdata),
        .ld_data   (mem_rdata),
        .st_lane   (st_lane),
        .ld_value  (ld_value)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            off_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            out_valid <= 1'b0;
            out_ale   <= 1'b0;
            out_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q  <= in_lsu_op;
                        off_q <= in_off;
                        if (in_kind == K_PASS || in_misaligned) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            out_ale   <= in_misaligned;
                            out_rdata <= in_misaligned ? '0 : DATA_WIDTH'(in_addr);
                        end else begin
                            state     <= S_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= (in_kind == K_STORE);
                            mem_addr  <= {in_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata <= (in_kind == K_STORE) ? st_lane : '0;
                            mem_wmask <= (in_kind == K_STORE) ? in_mask : '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        state   <= S_WAIT;
                        mem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // Store completion is the write acknowledge; its result is zero.
                    if (mem_rvalid) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        out_ale   <= 1'b0;
                        out_rdata <= (op_kind(op_q, WIDE) == K_LOAD) ? ld_value : '0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Runs a 32-bit and a 64-bit load_store_unit side by side, each with its own
// memory handshake, against a cycle-timeline reference model.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic [63:0] in_wdata;
    logic [63:0] mem_rdata;
    logic [1:0]  out_ready, mem_gnt, mem_rvalid;

    wire  [1:0]  in_ready, out_valid, out_ale, mem_req, mem_we;
    wire  [31:0] rdata32, wdata32, addr32, addr64;
    wire  [3:0]  mask32;
    wire  [63:0] rdata64, wdata64;
    wire  [7:0]  mask64;

    wire  [63:0] o_rdata [2];
    wire  [63:0] o_wdata [2];
    wire  [31:0] o_addr  [2];
    wire  [7:0]  o_mask  [2];
    assign o_rdata[0] = {32'b0, rdata32};
    assign o_rdata[1] = rdata64;
    assign o_wdata[0] = {32'b0, wdata32};
    assign o_wdata[1] = wdata64;
    assign o_addr[0]  = addr32;
    assign o_addr[1]  = addr64;
    assign o_mask[0]  = {4'b0, mask32};
    assign o_mask[1]  = mask64;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready[0]), .in_lsu_op(in_op),
        .in_addr(in_addr), .in_wdata(in_wdata[31:0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_rdata(rdata32), .out_ale(out_ale[0]),
        .mem_req(mem_req[0]), .mem_gnt(mem_gnt[0]), .mem_we(mem_we[0]),
        .mem_addr(addr32), .mem_wdata(wdata32), .mem_wmask(mask32),
        .mem_rvalid(mem_rvalid[0]), .mem_rdata(mem_rdata[31:0])
    );

    load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready[1]), .in_lsu_op(in_op),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_rdata(rdata64), .out_ale(out_ale[1]),
        .mem_req(mem_req[1]), .mem_gnt(mem_gnt[1]), .mem_we(mem_we[1]),
        .mem_addr(addr64), .mem_wdata(wdata64), .mem_wmask(mask64),
        .mem_rvalid(mem_rvalid[1]), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[dw%0d]: observed %h expected %h", tag, (d == 1) ? 64 : 32, obs, exp);
        end
    endtask

    // Reference: what a dw-bit unit must do with one request, from the opcode table
    // and alignment/extension rules, using plain arithmetic.
    function automatic void predict(input int dw, input logic [3:0] op, input logic [31:0] addr,
                                    input logic [63:0] wd, input logic [63:0] rd,
                                    output bit ismem, output bit we, output logic [31:0] maddr,
                                    output logic [63:0] mwdata, output logic [7:0] mmask,
                                    output logic [63:0] res, output bit ale);
        int nb, off, sz;
        bit ld, st, sgn;
        logic [127:0] full, t;
        nb   = dw / 8;
        off  = int'(addr % nb);
        sz   = 1 << op[1:0];
        ld   = (op inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9}) || (op == 4'd3 && dw == 64);
        st   = (op inside {4'd4, 4'd5, 4'd6}) || (op == 4'd7 && dw == 64);
        sgn  = !(op inside {4'd8, 4'd9});
        full = (128'd1 << dw) - 128'd1;
        ismem = 0; we = 0; maddr = '0; mwdata = '0; mmask = '0; res = '0; ale = 0;
        if (!ld && !st) begin
            res = {32'b0, addr};
        end else if (off % sz != 0) begin
            ale = 1;
        end else begin
            ismem = 1;
            maddr = addr - 32'(off);
            we    = st;
            if (st) begin
                mmask  = 8'(((1 << sz) - 1) << off);
                t      = ((128'(wd) & full) << (8 * off)) & full;
                mwdata = 64'(t);
            end else begin
                t = (128'(rd) & full) >> (8 * off);
                t = t & ((128'd1 << (8 * sz)) - 128'd1);
                if (sgn && t >= (128'd1 << (8 * sz - 1)))
                    t = t - (128'd1 << (8 * sz));
                res = 64'(t & full);
            end
        end
    endfunction

    // One request to both units; gd/rdd/yd = extra cycles before grant,
    // response and out_ready. Handshake inputs outside their window are random.
    task automatic txn(input logic [3:0] op, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [63:0] rd, input int gd, input int rdd, input int yd);
        bit ism[2], we_e[2], ale_e[2];
        logic [31:0] ma[2];
        logic [63:0] mw[2], rv[2];
        logic [7:0]  mm[2];
        int req_end[2], wait_end[2], ds[2], de[2];
        int last;
        last = 0;
        for (int d = 0; d < 2; d++) begin
            predict((d == 1) ? 64 : 32, op, addr, wd, rd, ism[d], we_e[d], ma[d], mw[d], mm[d], rv[d], ale_e[d]);
            req_end[d]  = ism[d] ? 1 + gd : 0;
            wait_end[d] = ism[d] ? req_end[d] + 1 + rdd : 0;
            ds[d]       = ism[d] ? wait_end[d] + 1 : 1;
            de[d]       = ds[d] + yd;
            if (de[d] + 1 > last) last = de[d] + 1;
        end
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wd; mem_rdata = rd;
        for (int d = 0; d < 2; d++) chk("in_ready_idle", d, 64'(in_ready[d]), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = 4'($urandom);
        in_addr  = $urandom;
        in_wdata = {$urandom, $urandom};
        for (int c = 1; c <= last; c++) begin
            for (int d = 0; d < 2; d++) begin
                bit er, ev;
                er = ism[d] && c <= req_end[d];
                ev = c >= ds[d] && c <= de[d];
                chk("mem_req", d, 64'(mem_req[d]), 64'(er));
                if (er) begin
                    chk("mem_addr", d, 64'(o_addr[d]), 64'(ma[d]));
                    chk("mem_we", d, 64'(mem_we[d]), 64'(we_e[d]));
                    chk("mem_wdata", d, o_wdata[d], mw[d]);
                    chk("mem_wmask", d, 64'(o_mask[d]), 64'(mm[d]));
                end
                chk("out_valid", d, 64'(out_valid[d]), 64'(ev));
                if (ev) begin
                    chk("out_rdata", d, o_rdata[d], rv[d]);
                    chk("out_ale", d, 64'(out_ale[d]), 64'(ale_e[d]));
                end
                chk("in_ready", d, 64'(in_ready[d]), 64'(c > de[d]));
                mem_gnt[d]    = er ? (c == req_end[d]) : 1'($urandom);
                mem_rvalid[d] = (ism[d] && c > req_end[d] && c <= wait_end[d]) ? (c == wait_end[d]) : 1'($urandom);
                out_ready[d]  = ev ? (c == de[d]) : 1'($urandom);
            end
            @(negedge clk);
        end
        mem_gnt = '0; mem_rvalid = '0; out_ready = '0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_addr = '0; in_wdata = '0;
        mem_rdata = '0; out_ready = '0; mem_gnt = '0; mem_rvalid = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", d, 64'(out_valid[d]), 64'd0);
            chk("rst_out_ale", d, 64'(out_ale[d]), 64'd0);
            chk("rst_out_rdata", d, o_rdata[d], 64'd0);
            chk("rst_mem_req", d, 64'(mem_req[d]), 64'd0);
            chk("rst_mem_we", d, 64'(mem_we[d]), 64'd0);
            chk("rst_mem_addr", d, 64'(o_addr[d]), 64'd0);
            chk("rst_mem_wdata", d, o_wdata[d], 64'd0);
            chk("rst_mem_wmask", d, 64'(o_mask[d]), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("rst_in_ready", d, 64'(in_ready[d]), 64'd1);

        txn(4'b0100, 32'h0000_1003, 64'hAB, 64'h0, 0, 0, 0);                    // ST.B lane 3
        txn(4'b0001, 32'h0000_2002, 64'h0, 64'h8001_1234, 0, 0, 0);             // LD.H sign
        txn(4'b1001, 32'h0000_2002, 64'h0, 64'h8001_1234, 0, 0, 0);             // LD.HU
        txn(4'b0010, 32'h0000_3001, 64'h0, 64'h0, 0, 0, 0);                     // misaligned LD.W
        txn(4'b0110, 32'h0000_5008, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 4, 0, 3);  // slow grant/ready
        txn(4'b0010, 32'h0000_4004, 64'h0, 64'h8000_0000_0000_0000, 0, 0, 0);  // LD.W upper half
        txn(4'b0011, 32'h0000_6000, 64'h0, 64'hF123_4567_89AB_CDEF, 1, 2, 1);  // LD.D / passthrough
        txn(4'b0111, 32'h0000_7005, 64'h1, 64'h0, 0, 0, 0);                     // ST.D misaligned / pass
        txn(4'b1111, 32'hFEDC_BA98, 64'h0, 64'h0, 0, 0, 2);                     // passthrough

        // Reset while waiting for the response, then a stray response.
        in_valid = 1'b1; in_op = 4'b0010; in_addr = 32'h0000_0100; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0; mem_gnt = 2'b11;
        @(negedge clk);
        mem_gnt = 2'b00;
        for (int d = 0; d < 2; d++) chk("wait_no_req", d, 64'(mem_req[d]), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; mem_rvalid = 2'b11;
        for (int d = 0; d < 2; d++) chk("abandon_in_ready", d, 64'(in_ready[d]), 64'd1);
        @(negedge clk);
        mem_rvalid = 2'b00;
        for (int d = 0; d < 2; d++) begin
            chk("stray_out_valid", d, 64'(out_valid[d]), 64'd0);
            chk("stray_in_ready", d, 64'(in_ready[d]), 64'd1);
        end

        for (int n = 0; n < 80; n++) begin
            op = ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
            a  = $urandom;
            if ($urandom % 2 == 1) a = a & ~32'h7;
            txn(op, a, {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
